// File: rtl/fp_addsub.sv
// Multi-cycle floating-point adder/subtractor (IDLE>ALIGN>ADD>NORM>ROUND>DONE), flush-to-zero.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_addsub #(
    parameter int unsigned EXP_WIDTH = 8,
    parameter int unsigned MAN_WIDTH = 23
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   data_a,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   data_b,
    input  logic                           op_sub,
    input  logic                           input_rdy,
    output logic                           input_ack,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   result,
    output logic                           output_rdy,
    input  logic                           output_ack
);

    localparam int unsigned EW  = EXP_WIDTH;
    localparam int unsigned MW  = MAN_WIDTH;
    localparam int unsigned W   = 1 + EW + MW;
    localparam int unsigned XW  = MW + 4;
    localparam int unsigned SW  = 2 * XW;
    localparam int unsigned LZW = $clog2(XW + 1);
    localparam logic [EW-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           input_ack_q, input_ack_d;
    logic           output_rdy_q, output_rdy_d;
    logic [W-1:0]   result_q, result_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic           sub_q, sub_d;
    logic           special_q, special_d;
    logic [W-1:0]   special_val_q, special_val_d;
    logic           sign_q, sign_d;
    logic           eff_sub_q, eff_sub_d;
    logic [EW:0]    exp_q, exp_d;
    logic [XW-1:0]  x_q, x_d, y_q, y_d;
    logic [XW:0]    sum_q, sum_d;
    logic [XW-1:0]  norm_q, norm_d;
    logic           zero_q, zero_d;

    // Alignment: unpack, classify specials, order by magnitude, shift the smaller operand
    logic [EW-1:0]  ea, eb, ex, ey, ediff;
    logic [MW-1:0]  ma, mb;
    logic           sa, sb, a_nan, b_nan, a_inf, b_inf, a_ge;
    logic [XW-1:0]  xa_ext, xb_ext, x_al, y_pre, y_al;
    logic [SW-1:0]  y_win;
    logic           al_special, al_sign;
    logic [W-1:0]   al_special_val;

    always_comb begin : align_logic
        ea     = a_q[W-2 -: EW];
        eb     = b_q[W-2 -: EW];
        ma     = a_q[MW-1:0];
        mb     = b_q[MW-1:0];
        sa     = a_q[W-1];
        sb     = b_q[W-1] ^ sub_q;
        a_nan  = (ea == EXP_MAX) && (ma != '0);
        b_nan  = (eb == EXP_MAX) && (mb != '0);
        a_inf  = (ea == EXP_MAX) && (ma == '0);
        b_inf  = (eb == EXP_MAX) && (mb == '0);
        xa_ext = (ea == '0) ? '0 : {1'b1, ma, 3'b000};
        xb_ext = (eb == '0) ? '0 : {1'b1, mb, 3'b000};
        a_ge   = {ea, xa_ext} >= {eb, xb_ext};
        if (a_ge) begin
            ex = ea; ey = eb; x_al = xa_ext; y_pre = xb_ext; al_sign = sa;
        end else begin
            ex = eb; ey = ea; x_al = xb_ext; y_pre = xa_ext; al_sign = sb;
        end
        ediff = ex - ey;
        y_win = '0;
        if (32'(ediff) >= XW) begin
            y_al = {(XW-1)'(0), |y_pre};
        end else begin
            y_win = {y_pre, XW'(0)} >> ediff;
            y_al  = {y_win[SW-1:XW+1], y_win[XW] | (|y_win[XW-1:0])};
        end
        al_special = a_nan | b_nan | a_inf | b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (sa ^ sb))) begin
            al_special_val = '1;
        end else if (a_inf) begin
            al_special_val = {sa, EXP_MAX, MW'(0)};
        end else begin
            al_special_val = {sb, EXP_MAX, MW'(0)};
        end
    end

    // Normalisation: carry shifts right, otherwise a single-cycle leading-zero shift
    logic [LZW-1:0] lz;
    logic [XW-1:0]  nm;
    logic [EW:0]    ne;
    logic           nz, nsign;

    always_comb begin : norm_logic
        lz = LZW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (sum_q[i]) lz = LZW'(XW - 1 - i);
        end
        nm    = '0;
        ne    = '0;
        nz    = 1'b0;
        nsign = sign_q;
        if (sum_q[XW]) begin
            nm = {sum_q[XW:2], sum_q[1] | sum_q[0]};
            ne = exp_q + (EW+1)'(1);
        end else if (32'(lz) == XW) begin
            nz    = 1'b1;
            nsign = sign_q & ~eff_sub_q;
        end else if (32'(lz) >= 32'(exp_q)) begin
            nz = 1'b1;
        end else begin
            nm = sum_q[XW-1:0] << lz;
            ne = exp_q - (EW+1)'(lz);
        end
    end

    // Rounding and final packing, including overflow to infinity
    logic            rup;
    logic [MW+1:0]   rm;
    logic [EW:0]     re;
    logic [W-1:0]    rres;
    logic [2:0]      unused_grs;

    always_comb begin : round_logic
`ifdef FP_ADDSUB_RNE_EN
        rup        = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        unused_grs = '0;
`else
        rup        = 1'b0;
        unused_grs = norm_q[2:0];
`endif
        rm = {1'b0, norm_q[XW-1:3]} + (MW+2)'(rup);
        re = exp_q + (EW+1)'(rm[MW+1]);
        if (special_q) begin
            rres = special_val_q;
        end else if (zero_q) begin
            rres = {sign_q, (W-1)'(0)};
        end else if (re >= {1'b0, EXP_MAX}) begin
            rres = {sign_q, EXP_MAX, MW'(0)};
        end else if (rm[MW+1]) begin
            rres = {sign_q, re[EW-1:0], rm[MW:1]};
        end else begin
            rres = {sign_q, re[EW-1:0], rm[MW-1:0]};
        end
    end

    always_comb begin : fsm_next
        state_d       = state_q;
        input_ack_d   = 1'b0;
        output_rdy_d  = 1'b0;
        result_d      = result_q;
        a_d           = a_q;
        b_d           = b_q;
        sub_d         = sub_q;
        special_d     = special_q;
        special_val_d = special_val_q;
        sign_d        = sign_q;
        eff_sub_d     = eff_sub_q;
        exp_d         = exp_q;
        x_d           = x_q;
        y_d           = y_q;
        sum_d         = sum_q;
        norm_d        = norm_q;
        zero_d        = zero_q;
        case (state_q)
            S_IDLE: begin
                if (input_rdy) begin
                    a_d         = data_a;
                    b_d         = data_b;
                    sub_d       = op_sub;
                    input_ack_d = 1'b1;
                    state_d     = S_ALIGN;
                end
            end
            S_ALIGN: begin
                special_d     = al_special;
                special_val_d = al_special_val;
                sign_d        = al_sign;
                eff_sub_d     = sa ^ sb;
                exp_d         = {1'b0, ex};
                x_d           = x_al;
                y_d           = y_al;
                state_d       = S_ADD;
            end
            S_ADD: begin
                sum_d   = eff_sub_q ? ({1'b0, x_q} - {1'b0, y_q}) : ({1'b0, x_q} + {1'b0, y_q});
                state_d = S_NORM;
            end
            S_NORM: begin
                norm_d  = nm;
                exp_d   = ne;
                zero_d  = nz;
                sign_d  = nsign;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                result_d     = rres;
                output_rdy_d = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (output_ack) state_d = S_IDLE;
                else            output_rdy_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            input_ack_q   <= 1'b0;
            output_rdy_q  <= 1'b0;
            result_q      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            sub_q         <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            sign_q        <= 1'b0;
            eff_sub_q     <= 1'b0;
            exp_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            sum_q         <= '0;
            norm_q        <= '0;
            zero_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            input_ack_q   <= input_ack_d;
            output_rdy_q  <= output_rdy_d;
            result_q      <= result_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sub_q         <= sub_d;
            special_q     <= special_d;
            special_val_q <= special_val_d;
            sign_q        <= sign_d;
            eff_sub_q     <= eff_sub_d;
            exp_q         <= exp_d;
            x_q           <= x_d;
            y_q           <= y_d;
            sum_q         <= sum_d;
            norm_q        <= norm_d;
            zero_q        <= zero_d;
        end
    end

    assign input_ack  = input_ack_q;
    assign output_rdy = output_rdy_q;
    assign result     = result_q;

endmodule
